// File: rtl/adc_axil_regbank.sv
// adc_axil_regbank: AXI4-Lite slave register bank for the ADC capture path.
//   NUM_CTRL RW control words, NUM_CH RO sample words, one overrange status word.
// Latency: write commits and BVALID rise the cycle after the later AW/W handshake;
//   RVALID/RDATA the cycle after the AR handshake.
// Backpressure: one outstanding write and one outstanding read. AWREADY/WREADY
//   drop once their beat is buffered or a B response is pending. ARREADY drops
//   while RVALID is high.
//
// Ports:
//   ACLK, ARESET         clock, asynchronous active-high reset
//   S_AXI_AW*/W*/B*      AXI4-Lite write channels (AWPROT not present)
//   S_AXI_AR*/R*         AXI4-Lite read channels (ARPROT not present)
//   adc_data/adc_valid   sample stream, channel 0 in the LSBs
//   adc_ovr              per-channel overrange, qualified by adc_valid
//   ctrl_out             control words, word 0 in the LSBs
//
// Build option: define ADC_REGBANK_OVR_STICKY_EN for sticky overrange bits that
//   only W1C or reset clears. Without it the status bits follow adc_ovr on
//   every adc_valid, and W1C writes are accepted but have no effect.
//
// Word map (word index = byte address >> 2):
//   0 .. NUM_CTRL-1                 control, RW with byte strobes
//   NUM_CTRL .. NUM_CTRL+NUM_CH-1   samples, RO, zero-extended
//   NUM_CTRL+NUM_CH                 status, bit c = overrange on channel c
//   above                           unmapped, SLVERR
module adc_axil_regbank #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 6,
  parameter int NUM_CTRL     = 4,
  parameter int NUM_CH       = 2,
  parameter int SAMPLE_WIDTH = 14
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  input  logic [NUM_CH*SAMPLE_WIDTH-1:0] adc_data,
  input  logic                           adc_valid,
  input  logic [NUM_CH-1:0]              adc_ovr,
  output logic [NUM_CTRL*DATA_WIDTH-1:0] ctrl_out
);

  localparam int WORD_W   = ADDR_WIDTH - 2;
  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int STAT_IDX = NUM_CTRL + NUM_CH;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic { WR_IDLE, WR_RESP } wr_state_t;
  typedef enum logic { RD_IDLE, RD_RESP } rd_state_t;

  wr_state_t wr_state;
  rd_state_t rd_state;

  // Readies stay low for the first cycle after reset release.
  logic ready_en;

  logic                     aw_full;
  logic [WORD_W-1:0]        aw_word;
  logic                     w_full;
  logic [DATA_WIDTH-1:0]    w_data;
  logic [STRB_W-1:0]        w_strb;
  logic [1:0]               bresp;
  logic [1:0]               rresp;
  logic [DATA_WIDTH-1:0]    rdata;

  logic [NUM_CTRL-1:0][DATA_WIDTH-1:0] ctrl_q;
  logic [NUM_CH-1:0][SAMPLE_WIDTH-1:0] sample_q;
  logic [NUM_CH-1:0]                   status_q;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic                  wr_fire;
  logic [WORD_W-1:0]     wr_word;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;
  int                    wr_idx;
  logic                  wr_ok;
  int                    rd_idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  rd_err;

  // Byte-offset bits of both addresses are ignored.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign S_AXI_AWREADY = ready_en && !aw_full && (wr_state == WR_IDLE);
  assign S_AXI_WREADY  = ready_en && !w_full  && (wr_state == WR_IDLE);
  assign S_AXI_BVALID  = (wr_state == WR_RESP);
  assign S_AXI_BRESP   = bresp;
  assign S_AXI_ARREADY = ready_en && (rd_state == RD_IDLE);
  assign S_AXI_RVALID  = (rd_state == RD_RESP);
  assign S_AXI_RRESP   = rresp;
  assign S_AXI_RDATA   = rdata;
  assign ctrl_out      = ctrl_q;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // The write commits on the edge that completes the second of AW/W. Take each
  // field from its buffer if already held, otherwise straight from the bus.
  assign wr_word = aw_full ? aw_word : S_AXI_AWADDR[ADDR_WIDTH-1:2];
  assign wr_data = w_full  ? w_data  : S_AXI_WDATA;
  assign wr_strb = w_full  ? w_strb  : S_AXI_WSTRB;
  assign wr_fire = (aw_full || aw_hs) && (w_full || w_hs);
  assign wr_idx  = int'(wr_word);
  assign wr_ok   = (wr_idx < NUM_CTRL) || (wr_idx == STAT_IDX);

  // Read mux over the current register values. A write committing on the same
  // edge therefore does not show up in this read.
  always_comb begin
    rd_idx  = int'(S_AXI_ARADDR[ADDR_WIDTH-1:2]);
    rd_word = '0;
    rd_err  = 1'b1;
    for (int i = 0; i < NUM_CTRL; i++) begin
      if (rd_idx == i) begin
        rd_word = ctrl_q[i];
        rd_err  = 1'b0;
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_idx == NUM_CTRL + c) begin
        rd_word[SAMPLE_WIDTH-1:0] = sample_q[c];
        rd_err                    = 1'b0;
      end
    end
    if (rd_idx == STAT_IDX) begin
      rd_word[NUM_CH-1:0] = status_q;
      rd_err              = 1'b0;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  // Write FSM: gather AW and W in either order, then hold B until BREADY.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_state <= WR_IDLE;
      aw_full  <= 1'b0;
      aw_word  <= '0;
      w_full   <= 1'b0;
      w_data   <= '0;
      w_strb   <= '0;
      bresp    <= RESP_OKAY;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          if (wr_fire) begin
            wr_state <= WR_RESP;
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            bresp    <= wr_ok ? RESP_OKAY : RESP_SLVERR;
          end else begin
            if (aw_hs) begin
              aw_full <= 1'b1;
              aw_word <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
              w_full <= 1'b1;
              w_data <= S_AXI_WDATA;
              w_strb <= S_AXI_WSTRB;
            end
          end
        end
        WR_RESP: begin
          if (S_AXI_BREADY) begin
            wr_state <= WR_IDLE;
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  // Read FSM: capture data on AR, hold R until RREADY.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rd_state <= RD_IDLE;
      rdata    <= '0;
      rresp    <= RESP_OKAY;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (ar_hs) begin
            rd_state <= RD_RESP;
            rdata    <= rd_word;
            rresp    <= rd_err ? RESP_SLVERR : RESP_OKAY;
          end
        end
        RD_RESP: begin
          if (S_AXI_RREADY) begin
            rd_state <= RD_IDLE;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  // Control words, byte-enabled.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      ctrl_q <= '0;
    end else if (wr_fire) begin
      for (int i = 0; i < NUM_CTRL; i++) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (wr_idx == i && wr_strb[b]) begin
            ctrl_q[i][8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end
    end
  end

  // Sample capture, gated by RUN (control word 0 bit 0).
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      sample_q <= '0;
    end else if (ctrl_q[0][0] && adc_valid) begin
      sample_q <= adc_data;
    end
  end

`ifdef ADC_REGBANK_OVR_STICKY_EN
  logic [DATA_WIDTH-1:0] byte_mask;
  logic [NUM_CH-1:0]     w1c_clr;

  always_comb begin
    byte_mask = '0;
    for (int b = 0; b < STRB_W; b++) begin
      byte_mask[8*b +: 8] = {8{wr_strb[b]}};
    end
  end

  assign w1c_clr = (wr_fire && wr_idx == STAT_IDX) ?
                   (wr_data[NUM_CH-1:0] & byte_mask[NUM_CH-1:0]) : '0;

  // Clear is applied first so a same-cycle overrange set wins.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      status_q <= '0;
    end else begin
      status_q <= (status_q & ~w1c_clr) | (adc_valid ? adc_ovr : '0);
    end
  end
`else
  // Status tracks the most recent qualified overrange flags.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      status_q <= '0;
    end else if (adc_valid) begin
      status_q <= adc_ovr;
    end
  end
`endif

endmodule

// File: doc/adc_axil_regbank.md
# adc_axil_regbank

Parametrised AXI4-Lite slave register bank for the ADC capture IPs: NUM_CTRL read/write control words, NUM_CH read-only per-channel sample words captured from the ADC sample stream, and one overrange status word. Successor to the fixed four-register AXI4-Lite slave: it generalises register count, channel count and sample width, and adds byte strobes, error responses, live sample capture and overrange flags. It sits between the PS AXI interconnect and the ADC data-path logic.

## Interface
- DATA_WIDTH, 32, AXI data width; must be 32.
- ADDR_WIDTH, 6, AXI byte-address width; must hold (NUM_CTRL+NUM_CH+1)*4.
- NUM_CTRL, 4, number of RW control words (1..8).
- NUM_CH, 2, number of ADC channels (1..8).
- SAMPLE_WIDTH, 14, ADC sample width (1..32).

- ACLK  in  1  clock for all logic.
- ARESET  in  1  reset; asynchronous, active-high.
- S_AXI_AWADDR/AWVALID/AWREADY  in/in/out  ADDR_WIDTH/1/1  write address channel (AWPROT ignored).
- S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  32/4/1/1  write data channel.
- S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response.
- S_AXI_ARADDR/ARVALID/ARREADY  in/in/out  ADDR_WIDTH/1/1  read address (ARPROT ignored).
- S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  32/2/1/1  read data.
- adc_data  in  NUM_CH*SAMPLE_WIDTH  sample per channel, channel 0 in LSBs.
- adc_valid  in  1  qualifies adc_data/adc_ovr.
- adc_ovr  in  NUM_CH  per-channel overrange, qualified by adc_valid.
- ctrl_out  out  NUM_CTRL*32  current control words, word 0 in LSBs.

## Operation
- Word index = ADDR[ADDR_WIDTH-1:2]; ADDR[1:0] ignored.
- Map: 0..NUM_CTRL-1 control (RW, WSTRB byte enables); NUM_CTRL..NUM_CTRL+NUM_CH-1 sample (RO, zero-extended); NUM_CTRL+NUM_CH status (bits [NUM_CH-1:0] overrange); above: unmapped.
- Write to control: OKAY. Write to status: W1C with WSTRB applied, OKAY. Write to sample or unmapped: no effect, SLVERR (2'b10).
- Read mapped: data, OKAY. Read unmapped: 0, SLVERR.
- Capture: when ctrl word 0 bit 0 (RUN) = 1 and adc_valid = 1, every sample register loads its channel. RUN = 0 freezes samples.
- Overrange: when adc_valid and adc_ovr[c], status bit c sets. Set and W1C on the same bit in the same cycle: set wins.
- Write FSM: IDLE → collect AW and W independently (either order or same cycle, each buffered once) → RESP (BVALID) → IDLE on BREADY. One outstanding write.
- Read FSM: IDLE → RESP (RVALID) on AR handshake → IDLE on RREADY. One outstanding read.
- Write and read in the same cycle to the same word: read returns the pre-write value.

## Timing
- Reset: AWREADY=WREADY=ARREADY=0 for the first cycle after release, then 1; BVALID=RVALID=0; BRESP=RRESP=0; RDATA=0; all control, sample, status = 0; ctrl_out = 0.
- AWREADY high only while no AW buffered and BVALID=0; WREADY likewise for W.
- Register update and BVALID in the cycle after the later of AW/W handshake; ctrl_out reflects the write in that same cycle.
- RVALID and RDATA in the cycle after AR handshake; ARREADY=0 while RVALID=1.
- BVALID/RVALID, BRESP/RRESP and RDATA stable until accepted.
- Sample/status registers update the cycle after adc_valid; a read accepted in that cycle returns the old value.
- ARESET mid-transaction: outstanding response dropped, all state returns to reset values immediately.

## Configuration
- ADC_REGBANK_OVR_STICKY_EN defined: status bits are sticky, cleared only by W1C or reset.
- Not defined: status bits mirror adc_ovr on each adc_valid (set or cleared per sample); W1C writes still return OKAY but have no effect.

## Test plan
- Write 0x00000001..0x00000004 to byte addresses 0x0,0x4,0x8,0xC, read back → identical data, all OKAY, ctrl_out matches.
- Write 0xAABBCCDD to 0x4 with WSTRB=4'b0101 over 0x11223344 → readback 0x11BB33DD.
- RUN=1, adc_valid with ch0=0x1ABC, ch1=0x0123 → 0x10 reads 0x00001ABC, 0x14 reads 0x00000123; RUN=0 then new samples → values unchanged.
- Write to 0x10 and read 0x3C → both SLVERR, read data 0, sample unchanged.
- adc_ovr=2'b10 with adc_valid, then 2'b00 → status 0x2 (sticky build) / 0x0 (non-sticky); W1C 0x2 → 0x0; W1C coinciding with new overrange on bit 1 → bit 1 remains 1.
- WVALID asserted 3 cycles before AWVALID, BREADY held low 5 cycles → single BVALID held stable, no second write accepted until B completes.
